// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit register: hold, shift right/left, parallel load, saturating shift counter.
// Optional registered parity output is enabled by defining USR_PARITY_EN.
module universal_shift_reg #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0,
  localparam int unsigned           CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             sir,
  input  logic             sil,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sor,
  output logic             sol,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             drained
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  mode_e            op;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  assign op      = mode_e'(mode);
  assign cnt_inc = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + 1'b1;

  always_comb begin
    q_next   = q;
    cnt_next = shift_cnt;
    if (clr) begin
      q_next   = RESET_VAL;
      cnt_next = '0;
    end else if (en) begin
      unique case (op)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_next   = {sir, q[WIDTH-1:1]};
          cnt_next = cnt_inc;
        end
        MODE_SHL: begin
          q_next   = {q[WIDTH-2:0], sil};
          cnt_next = cnt_inc;
        end
        MODE_LOAD: begin
          q_next   = d;
          cnt_next = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
    end else begin
      q         <= q_next;
      shift_cnt <= cnt_next;
    end
  end

`ifdef USR_PARITY_EN
  // Parity tracks the value being written so it never lags q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity <= ^RESET_VAL;
    else        parity <= ^q_next;
  end
`endif

  assign sor     = q[0];
  assign sol     = q[WIDTH-1];
  assign drained = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH = 8, RESET_VAL = 0).
module tb_universal_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic             sir;
  logic             sil;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sor;
  logic             sol;
  logic [CNT_W-1:0] shift_cnt;
  logic             drained;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  universal_shift_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(8'h00)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .mode     (mode),
    .sir      (sir),
    .sil      (sil),
    .d        (d),
    .q        (q),
    .sor      (sor),
    .sol      (sol),
    .shift_cnt(shift_cnt),
    .drained  (drained)
`ifdef USR_PARITY_EN
    ,
    .parity   (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] val);
    clr  = 1'b0;
    en   = 1'b1;
    mode = 2'b11;
    d    = val;
    tick();
  endtask

  logic [WIDTH-1:0] shr_exp [10];

  initial begin
    shr_exp = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; sir = 1'b0; sil = 1'b0; d = '0;
    #2;
    check("rst_q", 32'(q), 32'h00);
    check("rst_cnt", 32'(shift_cnt), 32'd0);
    // edges while reset is held must not update
    en = 1'b1; mode = 2'b11; d = 8'hFF;
    tick();
    check("rst_hold_q", 32'(q), 32'h00);
    rst_n = 1'b1;

    // 1: async reset mid-cycle
    load(8'hFF);
    check("load_ff", 32'(q), 32'hFF);
    mode = 2'b01; sir = 1'b1;
    tick();
    check("pre_rst_cnt", 32'(shift_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_q", 32'(q), 32'h00);
    check("async_cnt", 32'(shift_cnt), 32'd0);
`ifdef USR_PARITY_EN
    check("async_par", 32'(parity), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 2: load then right shift
    load(8'hA5);
    check("ld_a5_cnt", 32'(shift_cnt), 32'd0);
    mode = 2'b01; sir = 1'b0;
    tick();
    check("shr_q", 32'(q), 32'h52);
    check("shr_sor", 32'(sor), 32'd0);
    check("shr_cnt", 32'(shift_cnt), 32'd1);
`ifdef USR_PARITY_EN
    check("shr_par", 32'(parity), 32'd1);
`endif

    // 3: load then left shift
    load(8'hA5);
    mode = 2'b10; sil = 1'b1;
    tick();
    check("shl_q", 32'(q), 32'h4B);
    check("shl_sol", 32'(sol), 32'd0);
    check("shl_cnt", 32'(shift_cnt), 32'd1);
`ifdef USR_PARITY_EN
    check("shl_par", 32'(parity), 32'd0);
`endif

    // 4: ten right shifts, counter saturates at 8
    load(8'hA5);
    mode = 2'b01; sir = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("sat_q%0d", k), 32'(q), 32'(shr_exp[k-1]));
      check($sformatf("sat_cnt%0d", k), 32'(shift_cnt), (k > 8) ? 32'd8 : 32'(k));
      check($sformatf("sat_drn%0d", k), 32'(drained), (k >= 8) ? 32'd1 : 32'd0);
    end
    check("sat_sor", 32'(sor), 32'd1);

    // en=1 mode=00 holds q and counter
    mode = 2'b00;
    tick();
    check("hold_q", 32'(q), 32'hFF);
    check("hold_cnt", 32'(shift_cnt), 32'd8);

    // 5: clr beats load
    clr = 1'b1; en = 1'b1; mode = 2'b11; d = 8'h3C;
    tick();
    check("clr_q", 32'(q), 32'h00);
    check("clr_cnt", 32'(shift_cnt), 32'd0);
    check("clr_drn", 32'(drained), 32'd0);
    clr = 1'b0; en = 1'b0; mode = 2'b11;
    tick();
    check("clr_en0_q", 32'(q), 32'h00);

    // shift left after clear, then load zeroes counter
    en = 1'b1; mode = 2'b10; sil = 1'b1;
    tick();
    check("shl1_q", 32'(q), 32'h01);
    check("shl1_sor", 32'(sor), 32'd1);
    sil = 1'b0;
    tick();
    check("shl2_q", 32'(q), 32'h02);
    check("shl2_cnt", 32'(shift_cnt), 32'd2);
    load(8'h80);
    check("ld80_cnt", 32'(shift_cnt), 32'd0);
    check("ld80_sol", 32'(sol), 32'd1);

    // 6: en=0 blocks shifts
    load(8'hA5);
    en = 1'b0; mode = 2'b01; sir = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("en0_q%0d", k), 32'(q), 32'hA5);
      check($sformatf("en0_cnt%0d", k), 32'(shift_cnt), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
